// File: rtl/instruction_queue.sv
// Prefetch queue of instruction bytes from WBUS.
// Presents the head byte as opcode and the next byte as operand.
module instruction_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic [W-1:0]               WBUS,
    input  logic                       nLi,
    input  logic                       nRd,
    input  logic                       nFlush,
    output logic [W-1:0]               opcode,
    output logic [W-1:0]               operand,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_nxt;
    logic          ld;
    logic          rd;
    logic          empty;
    logic          do_ld;
    logic          do_rd;
    logic          err;

    always_comb begin
        ld       = ~nLi;
        rd       = ~nRd;
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        valid    = ~empty;
        // at full a same-edge pop frees the slot the load fills
        do_ld    = ld & (~full | rd);
        do_rd    = rd & ~empty;
        err      = (ld & full & ~rd) | (rd & empty);
        head_nxt = head + PW'(1);
        opcode   = valid ? mem[head] : '0;
        operand  = (count >= CW'(2)) ? mem[head_nxt] : '0;
    end

    always_ff @(negedge CLK) begin
        if (CLR) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!nFlush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_ld) begin
                mem[tail] <= WBUS;
                tail      <= tail + PW'(1);
            end
            if (do_rd) head <= head_nxt;
            if (do_ld && !do_rd)      count <= count + CW'(1);
            else if (!do_ld && do_rd) count <= count - CW'(1);
            if (err) ovf <= 1'b1;
        end
    end

endmodule
